execute_cycle: RTL and testbench



---
 rtl/pipe_pkg.sv | 21 ++
 rtl/alu.sv | 44 ++++
 rtl/execute_cycle.sv | 95 +++++++++
 tb/tb_execute_cycle.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU operation codes and forwarding selects.
package pipe_pkg;

    // ALU operation select codes driven by decode
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Operand forwarding selects from the hazard unit (2'b11 falls back to the register file)
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU with a zero flag for branch compares.
module alu
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    localparam int SHW = $clog2(XLEN);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic        [SHW-1:0]  shamt;

    assign a_s   = A;
    assign b_s   = B;
    assign shamt = B[SHW-1:0];

    // Operation select; unassigned codes yield zero
    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_AND:  Result = A & B;
            ALU_OR:   Result = A | B;
            ALU_ADD:  Result = A + B;
            ALU_XOR:  Result = A ^ B;
            ALU_SLL:  Result = A << shamt;
            ALU_SRL:  Result = A >> shamt;
            ALU_SUB:  Result = A - B;
            ALU_SLT:  Result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SRA:  Result = a_s >>> shamt;
            ALU_SLTU: Result = {{(XLEN-1){1'b0}}, (A < B)};
            default:  Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution and the EX/MEM register.
module execute_cycle
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            MemReadE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic [3:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [4:0]      RD_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            MemReadM,
    output logic            ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    // Forwarding mux shared by both operands; the unused code reads the register file
    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf_val,
        input logic [XLEN-1:0] wb_val,
        input logic [XLEN-1:0] mem_val
    );
        case (sel)
            FWD_WB:  return wb_val;
            FWD_MEM: return mem_val;
            default: return rf_val;
        endcase
    endfunction

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b_fwd;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;

    assign src_a     = fwd_mux(ForwardA_E, RD1_E, ResultW, ALUResultM);
    assign src_b_fwd = fwd_mux(ForwardB_E, RD2_E, ResultW, ALUResultM);
    assign alu_b     = ALUSrcE ? Imm_Ext_E : src_b_fwd;

    alu #(.XLEN(XLEN)) u_alu (
        .A          (src_a),
        .B          (alu_b),
        .ALUControl (ALUControlE),
        .Result     (alu_result),
        .Zero       (zero)
    );

    assign PCSrcE    = BranchE & zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    // ---- EX/MEM boundary: capture every edge, cleared whenever reset is asserted ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemReadM   <= 1'b0;
            ResultSrcM <= 1'b0;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            MemReadM   <= MemReadE;
            ResultSrcM <= ResultSrcE;
            RD_M       <= RD_E;
            ALUResultM <= alu_result;
            WriteDataM <= src_b_fwd;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for the execute stage.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, MemReadE, ResultSrcE, BranchE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, MemReadM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_cycle #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteE   (RegWriteE),
        .ALUSrcE     (ALUSrcE),
        .MemWriteE   (MemWriteE),
        .MemReadE    (MemReadE),
        .ResultSrcE  (ResultSrcE),
        .BranchE     (BranchE),
        .ALUControlE (ALUControlE),
        .RD1_E       (RD1_E),
        .RD2_E       (RD2_E),
        .Imm_Ext_E   (Imm_Ext_E),
        .RD_E        (RD_E),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .ForwardA_E  (ForwardA_E),
        .ForwardB_E  (ForwardB_E),
        .ResultW     (ResultW),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .MemReadM    (MemReadM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .PCPlus4M    (PCPlus4M)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; MemReadE = 0; ResultSrcE = 0; BranchE = 0;
        ALUControlE = 4'b0000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
        PCE = 0; PCPlus4E = 0; ForwardA_E = 2'b00; ForwardB_E = 2'b00; ResultW = 0;
    endtask

    // Independent reference: shifts built from 64-bit extensions, compares via offset-binary
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        logic [31:0] au, bu;
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a ^ b;
            4'd4: return a << sh;
            4'd5: return a >> sh;
            4'd6: return a + (~b) + 32'd1;
            4'd7: begin
                au = a ^ 32'h8000_0000;
                bu = b ^ 32'h8000_0000;
                return (au < bu) ? 32'd1 : 32'd0;
            end
            4'd8: begin
                ext = {{32{a[31]}}, a} >> sh;
                return ext[31:0];
            end
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        clear_inputs();
        ALUControlE = op; RD1_E = a; RD2_E = b;
        step();
        check(tag, ALUResultM, exp);
    endtask

    initial begin
        logic [31:0] a, b;
        clear_inputs();
        rst = 0;
        #2;
        check("reset_alu", ALUResultM, 32'd0);
        check("reset_regwrite", {31'd0, RegWriteM}, 32'd0);
        step();
        check("reset_held_after_edge", ALUResultM, 32'd0);
        #2 rst = 1;

        // ADD with immediate
        RD1_E = 5; Imm_Ext_E = 7; ALUSrcE = 1; ALUControlE = 4'b0010; RegWriteE = 1; RD_E = 3;
        MemReadE = 1; ResultSrcE = 1; PCPlus4E = 32'h44;
        step();
        check("add_imm_result", ALUResultM, 32'd12);
        check("add_imm_rd", {27'd0, RD_M}, 32'd3);
        check("add_imm_regwrite", {31'd0, RegWriteM}, 32'd1);
        check("add_imm_memread", {31'd0, MemReadM}, 32'd1);
        check("add_imm_resultsrc", {31'd0, ResultSrcM}, 32'd1);
        check("add_imm_pcplus4", PCPlus4M, 32'h44);

        // Forwarding from MEM (A) and WB (B), back-to-back
        clear_inputs();
        RD1_E = 3; Imm_Ext_E = 7; ALUSrcE = 1; ALUControlE = 4'b0010;
        step();
        check("fwd_setup", ALUResultM, 32'd10);
        clear_inputs();
        ForwardA_E = 2'b10; ForwardB_E = 2'b01; ResultW = 4; RD1_E = 32'h99; RD2_E = 32'h77;
        ALUControlE = 4'b0110;
        step();
        check("fwd_mem_wb_sub", ALUResultM, 32'd6);
        check("fwd_wb_writedata", WriteDataM, 32'd4);
        clear_inputs();
        RD1_E = 3; Imm_Ext_E = 7; ALUSrcE = 1; ALUControlE = 4'b0010;
        step();
        clear_inputs();
        ForwardA_E = 2'b10; ForwardB_E = 2'b11; RD2_E = 1; ResultW = 32'h50; ALUControlE = 4'b0110;
        step();
        check("fwd_b11_as_rf", ALUResultM, 32'd9);

        // Branch resolution (combinational)
        clear_inputs();
        BranchE = 1; ALUControlE = 4'b0110; RD1_E = 32'h1234; RD2_E = 32'h1234;
        PCE = 32'h100; Imm_Ext_E = 32'hFFFF_FFF0;
        #1;
        check("beq_taken", {31'd0, PCSrcE}, 32'd1);
        check("beq_target", PCTargetE, 32'h0000_00F0);
        RD2_E = 32'h1235;
        #1;
        check("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
        BranchE = 0; RD2_E = 32'h1234;
        #1;
        check("no_branch_flag", {31'd0, PCSrcE}, 32'd0);

        // Store data comes from the forwarded B, not the immediate
        clear_inputs();
        MemWriteE = 1; ALUSrcE = 1; ForwardB_E = 2'b01; ResultW = 32'hDEAD_BEEF;
        RD1_E = 32'h1000; RD2_E = 32'h55; Imm_Ext_E = 8; ALUControlE = 4'b0010;
        step();
        check("store_writedata", WriteDataM, 32'hDEAD_BEEF);
        check("store_memwrite", {31'd0, MemWriteM}, 32'd1);
        check("store_addr", ALUResultM, 32'h1008);

        // Reset mid-operation: asynchronous clear, capture resumes on next edge
        clear_inputs();
        RegWriteE = 1; RD_E = 9; RD1_E = 32'h20; RD2_E = 32'h3; ALUControlE = 4'b0010; PCPlus4E = 32'h88;
        step();
        check("pre_reset_result", ALUResultM, 32'h23);
        rst = 0;
        #1;
        check("async_reset_alu", ALUResultM, 32'd0);
        check("async_reset_rd", {27'd0, RD_M}, 32'd0);
        check("async_reset_regwrite", {31'd0, RegWriteM}, 32'd0);
        check("async_reset_pcplus4", PCPlus4M, 32'd0);
        BranchE = 1; ALUControlE = 4'b0110; RD1_E = 32'h7; RD2_E = 32'h7;
        #1;
        check("reset_pcsrc_comb", {31'd0, PCSrcE}, 32'd1);
        BranchE = 0; ALUControlE = 4'b0001; RD1_E = 32'hF0; RD2_E = 32'h0F;
        #1 rst = 1;
        #1;
        check("release_hold", ALUResultM, 32'd0);
        step();
        check("release_capture", ALUResultM, 32'h0000_00FF);
        check("release_capture_rd", {27'd0, RD_M}, 32'd9);

        // ALU boundary cases and undefined code
        run_op("sra_boundary", 4'b1000, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
        run_op("sltu_boundary", 4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_op("slt_boundary", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_op("srl_check", 4'b0101, 32'h8000_0000, 32'd31, 32'd1);
        run_op("sll_check", 4'b0100, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030);
        run_op("sub_wrap", 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF);
        run_op("undef_1111", 4'b1111, 32'h1234_5678, 32'h0F0F_0F0F, 32'd0);
        run_op("undef_1010", 4'b1010, 32'h1234_5678, 32'h0F0F_0F0F, 32'd0);

        // Random sweep of all ten operations
        for (int r = 0; r < 4; r++) begin
            for (int op = 0; op < 10; op++) begin
                a = $urandom;
                b = $urandom;
                run_op($sformatf("sweep_op%0d_r%0d", op, r), 4'(op), a, b, ref_alu(4'(op), a, b));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
